mem_arbiter: RTL
================

# mem_arbiter

Single-port SRAM arbiter and access sequencer for the 16-bit five-stage pipeline. It shares one external SRAM between instruction fetch (IF) and the MEM-stage load/store held in `ex_mem`. It generates the multi-cycle SRAM control waveforms and a pipeline-wide `stall_o` that freezes PC, IF/ID, ID/EX and EX/MEM until the cycle's accesses complete. MEM-stage accesses always take priority over fetch.

## Interface
- `WAIT_CYCLES`, default 1: extra SRAM access cycles, legal range 0..14.
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RST`  in  1  reset, synchronous and active-high.
- `if_req_i`  in  1  fetch request from IF.
- `if_addr_i`  in  16  fetch address (PC).
- `if_data_o`  out  16  fetched instruction; registered, held until the next fetch completes.
- `if_ready_o`  out  1  one-cycle pulse when `if_data_o` is updated.
- `memread_i`  in  1  load request from EX/MEM.
- `memwrite_i`  in  1  store request from EX/MEM.
- `mem_addr_i`  in  16  load/store address (`alures_o` of EX/MEM).
- `memdata_i`  in  16  store data.
- `mem_rdata_o`  out  16  load result; registered, held until the next load completes.
- `mem_ready_o`  out  1  one-cycle pulse at the end of a load or store.
- `stall_o`  out  1  pipeline freeze.
- `ram_addr_o`  out  16  SRAM address, registered.
- `ram_wdata_o`  out  16  SRAM write data, registered.
- `ram_rdata_i`  in  16  SRAM read data.
- `ram_ce_n_o`, `ram_oe_n_o`, `ram_we_n_o`  out  1 each  SRAM controls, active-low.
- `ram_dout_en_o`  out  1  drives the external data bus when high.

## Operation
- States: IDLE, DRD (data read), WSU (write setup), WPL (write pulse), WHD (write hold), IRD (instruction read). A 4-bit counter `cnt` runs in DRD, WPL and IRD.
- IDLE:
  - `memwrite_i` → WSU. `memwrite_i` wins if `memread_i` is also high.
  - else `memread_i` → DRD.
  - else `if_req_i` → IRD.
  - else stay in IDLE.
  - On any transition: latch the address into `ram_addr_o`, latch `memdata_i` into `ram_wdata_o` (writes only), and clear `cnt`.
  - Request inputs are sampled only in IDLE. Changes during an access are ignored.
- DRD and IRD: `ce_n=0`, `oe_n=0`, `we_n=1`, `dout_en=0`. Stay until `cnt==WAIT_CYCLES`.
  - On that last cycle, capture `ram_rdata_i` into `mem_rdata_o` (DRD) or `if_data_o` (IRD), and pulse `mem_ready_o` / `if_ready_o`.
- After DRD or WHD:
  - `if_req_i`=1 → IRD, with the address reloaded from `if_addr_i` and `cnt` cleared.
  - otherwise → IDLE.
- After IRD: → IDLE.
- Write sequence:
  - WSU, 1 cycle: `ce_n=0`, `we_n=1`, `dout_en=1`.
  - WPL, until `cnt==WAIT_CYCLES`: `we_n=0`.
  - WHD, 1 cycle: `we_n=1`, `dout_en=1`, `mem_ready_o` pulse.
- IDLE SRAM outputs: `ce_n=1`, `oe_n=1`, `we_n=1`, `dout_en=0`.
- `stall_o`:
  - In IDLE: equals `memread_i | memwrite_i | if_req_i`.
  - In every other state: 1, except 0 on the final cycle of the last access for the instruction. That is the last IRD cycle, or the last DRD/WHD cycle when `if_req_i`=0.
  - The pipeline therefore advances on the same edge the arbiter returns to IDLE, so one EX/MEM entry is never served twice.

## Timing
- Reset values: state IDLE, `cnt=0`, `if_data_o=0`, `mem_rdata_o=0`, `ram_addr_o=0`, `ram_wdata_o=0`, both ready pulses 0, `ram_ce_n_o=ram_oe_n_o=ram_we_n_o=1`, `ram_dout_en_o=0`.
- `stall_o` while RST is held follows the IDLE rule.
- SRAM control outputs are decoded from the state register only; they have no combinational path from the inputs.
- Fetch only: 1 IDLE cycle + (WAIT_CYCLES+1) IRD cycles. With WAIT_CYCLES=1 this is 3 cycles per instruction.
- Load plus fetch: 1 + 2·(WAIT_CYCLES+1) cycles.
- Store plus fetch: 1 + (WAIT_CYCLES+3) + (WAIT_CYCLES+1) cycles.
- `ram_addr_o` and `ram_wdata_o` are stable from WSU through WHD inclusive. `we_n` is never low while `dout_en`=0.
- RST asserted mid-access: the next edge forces IDLE with reset output values. No ready pulse is issued, and `we_n` returns to 1 on that edge.
- WAIT_CYCLES=0: DRD, WPL and IRD each last exactly 1 cycle.

## Test plan
All scenarios use WAIT_CYCLES=1.
- Reset: hold RST 2 cycles during a store in WPL → next edge `we_n=1`, `ce_n=1`, `dout_en=0`, no `mem_ready_o`, state IDLE.
- Fetch only: `if_req_i=1`, `if_addr_i=0x0010`, SRAM returns 0x1234 → `ce_n`/`oe_n` low for 2 cycles, `if_ready_o` and `if_data_o=0x1234` on cycle 3, `stall_o=0` only on cycle 3; repeats every 3 cycles.
- Load then fetch: `memread_i=1`, addr 0x8000 → SRAM 0xABCD, PC 0x0011 → SRAM 0x5A5A → `mem_ready_o` on cycle 3 with `mem_rdata_o=0xABCD`; `if_ready_o` on cycle 5 with 0x5A5A; `stall_o` high cycles 1–4, low on 5; `mem_rdata_o` still 0xABCD afterwards.
- Store: `memwrite_i=1`, addr 0x0003, data 0xDCBA, `if_req_i=0` → `ram_addr_o=0x0003` and `ram_wdata_o=0xDCBA` for 4 cycles, `we_n` low exactly 2 cycles, `mem_ready_o` on the WHD cycle, `stall_o=0` on WHD.
- Simultaneous `memread_i=memwrite_i=1` → the write sequence runs; no DRD, `oe_n` stays 1.
- Change `mem_addr_i` 0x0003→0x0100 during WPL → `ram_addr_o` stays 0x0003 until WHD completes.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter for the five-stage pipeline: sequences MEM-stage loads/stores
// ahead of instruction fetches and freezes the pipeline until the cycle's accesses finish.
module mem_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        if_req_i,
  input  logic [15:0] if_addr_i,
  output logic [15:0] if_data_o,
  output logic        if_ready_o,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [15:0] mem_addr_i,
  input  logic [15:0] memdata_i,
  output logic [15:0] mem_rdata_o,
  output logic        mem_ready_o,
  output logic        stall_o,
  output logic [15:0] ram_addr_o,
  output logic [15:0] ram_wdata_o,
  input  logic [15:0] ram_rdata_i,
  output logic        ram_ce_n_o,
  output logic        ram_oe_n_o,
  output logic        ram_we_n_o,
  output logic        ram_dout_en_o
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    DRD,
    WSU,
    WPL,
    WHD,
    IRD
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       last;
  logic       req_any;
  logic [3:0] ctrl;

  // SRAM strobes {ce_n, oe_n, we_n, dout_en} for each state; the bus is driven
  // through WSU..WHD so we_n can never fall while dout_en is low.
  function automatic logic [3:0] ctrl_of(input state_t s);
    case (s)
      DRD, IRD: ctrl_of = 4'b0010;
      WSU, WHD: ctrl_of = 4'b0111;
      WPL:      ctrl_of = 4'b0101;
      default:  ctrl_of = 4'b1110;
    endcase
  endfunction

  assign last    = (cnt == WAIT_CNT);
  assign req_any = memread_i | memwrite_i | if_req_i;
  assign ctrl    = ctrl_of(state);

  assign ram_ce_n_o    = ctrl[3];
  assign ram_oe_n_o    = ctrl[2];
  assign ram_we_n_o    = ctrl[1];
  assign ram_dout_en_o = ctrl[0];

  // Stall drops only on the final cycle of the instruction's last access, so the
  // pipeline advances on the same edge the arbiter returns to IDLE.
  always_comb begin
    stall_o = 1'b1;
    if (RST || state == IDLE) begin
      stall_o = req_any;
    end else begin
      case (state)
        DRD:     stall_o = !(last && !if_req_i);
        WHD:     stall_o = if_req_i;
        IRD:     stall_o = !last;
        default: stall_o = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      if_data_o   <= 16'd0;
      mem_rdata_o <= 16'd0;
      ram_addr_o  <= 16'd0;
      ram_wdata_o <= 16'd0;
      if_ready_o  <= 1'b0;
      mem_ready_o <= 1'b0;
    end else begin
      if_ready_o  <= 1'b0;
      mem_ready_o <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 4'd0;
          if (memwrite_i) begin
            state       <= WSU;
            ram_addr_o  <= mem_addr_i;
            ram_wdata_o <= memdata_i;
          end else if (memread_i) begin
            state      <= DRD;
            ram_addr_o <= mem_addr_i;
          end else if (if_req_i) begin
            state      <= IRD;
            ram_addr_o <= if_addr_i;
          end
        end
        DRD: begin
          if (last) begin
            mem_rdata_o <= ram_rdata_i;
            mem_ready_o <= 1'b1;
            cnt         <= 4'd0;
            if (if_req_i) begin
              state      <= IRD;
              ram_addr_o <= if_addr_i;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WSU: begin
          state <= WPL;
          cnt   <= 4'd0;
        end
        WPL: begin
          // The store completes as it enters the hold cycle, so its ready pulse lines up with WHD.
          if (last) begin
            state       <= WHD;
            mem_ready_o <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WHD: begin
          cnt <= 4'd0;
          if (if_req_i) begin
            state      <= IRD;
            ram_addr_o <= if_addr_i;
          end else begin
            state <= IDLE;
          end
        end
        IRD: begin
          if (last) begin
            if_data_o  <= ram_rdata_i;
            if_ready_o <= 1'b1;
            cnt        <= 4'd0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule
